// File: rtl/exec_result_buffer.sv
// Execute->memory boundary: two-entry skid buffer for ALU results plus branch/jump resolution.
// Optional RANGER_EXEC_STATS_EN adds stat_retired/stat_stall counters.
module exec_result_buffer #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_result,
    input  logic               in_zero,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_rd_we,
    input  logic               in_mem_rd,
    input  logic               in_mem_wr,
    input  logic [XLEN-1:0]    in_store_data,
    input  logic               in_branch,
    input  logic               in_br_on_zero,
    input  logic               in_jump,
    input  logic [XLEN-1:0]    in_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_result,
    output logic [XLEN-1:0]    out_store_data,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_rd_we,
    output logic               out_mem_rd,
    output logic               out_mem_wr,
    output logic               out_misalign,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc,
    output logic [1:0]         dbg_state
`ifdef RANGER_EXEC_STATS_EN
    ,
    output logic [31:0]        stat_retired,
    output logic [31:0]        stat_stall
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]    result;
        logic [XLEN-1:0]    store_data;
        logic [RADDR_W-1:0] rd;
        logic               rd_we;
        logic               mem_rd;
        logic               mem_wr;
        logic               misalign;
    } entry_t;

    state_t          state_q, state_d;
    entry_t          main_q, main_d;
    entry_t          skid_q, skid_d;
    entry_t          new_entry;
    logic            in_ready_q, in_ready_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            taken;
    logic            aligned;
    logic            accept;
    logic            transfer;

    // Handshake: accept = in_valid & in_ready, transfer = out_valid & out_ready; in_ready is registered.
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != S_EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign transfer  = out_valid & out_ready;

    always_comb begin
        taken   = in_jump | (in_branch & (in_zero == in_br_on_zero));
        aligned = (in_target[1:0] == 2'b00);

        new_entry            = '0;
        new_entry.result     = in_result;
        new_entry.store_data = in_store_data;
        new_entry.rd         = in_rd;
        new_entry.rd_we      = in_rd_we & (in_rd != '0);
        new_entry.mem_rd     = in_mem_rd;
        new_entry.mem_wr     = in_mem_wr;
        new_entry.misalign   = taken & ~aligned;
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    main_d  = new_entry;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && transfer) begin
                    main_d = new_entry;
                end else if (accept) begin
                    skid_d  = new_entry;
                    state_d = S_FULL;
                end else if (transfer) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (transfer) begin
                    main_d  = skid_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase

        // A flush from a later stage beats everything, including a same-cycle accept.
        if (flush) begin
            state_d = S_EMPTY;
        end

        in_ready_d       = (state_d != S_FULL);
        redirect_valid_d = accept & taken & aligned & ~flush;
        redirect_pc_d    = redirect_valid_d ? in_target : redirect_pc_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= S_EMPTY;
            main_q           <= '0;
            skid_q           <= '0;
            in_ready_q       <= 1'b1;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            main_q           <= main_d;
            skid_q           <= skid_d;
            in_ready_q       <= in_ready_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign out_result     = main_q.result;
    assign out_store_data = main_q.store_data;
    assign out_rd         = main_q.rd;
    assign out_rd_we      = main_q.rd_we;
    assign out_mem_rd     = main_q.mem_rd;
    assign out_mem_wr     = main_q.mem_wr;
    assign out_misalign   = main_q.misalign;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign dbg_state      = state_q;

`ifdef RANGER_EXEC_STATS_EN
    logic [31:0] stat_retired_q, stat_retired_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Counters ignore flush; they only observe the output handshake.
    always_comb begin
        stat_retired_d = stat_retired_q + (transfer ? 32'd1 : 32'd0);
        stat_stall_d   = stat_stall_q + ((out_valid & ~out_ready) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_retired_q <= '0;
            stat_stall_q   <= '0;
        end else begin
            stat_retired_q <= stat_retired_d;
            stat_stall_q   <= stat_stall_d;
        end
    end

    assign stat_retired = stat_retired_q;
    assign stat_stall   = stat_stall_q;
`endif

endmodule
